// File: rtl/vrf_port_arbiter_if.sv
// Requester/VRF-port bundle for vrf_port_arbiter.
// The master side holds the requesters and the VRF port; the slave side is the arbiter.
interface vrf_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int OFF_WIDTH  = 8
);
   localparam int SRC_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*OFF_WIDTH-1:0]  req_off;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            gnt;
   logic                          port_valid;
   logic [ADDR_WIDTH-1:0]         port_addr;
   logic [OFF_WIDTH-1:0]          port_off;
   logic                          port_last;
   logic [SRC_W-1:0]              port_src;
   logic                          port_ready;
   logic                          busy;

   modport master (
      output req_valid, req_addr, req_off, req_last, port_ready,
      input  gnt, port_valid, port_addr, port_off, port_last, port_src, busy
   );

   modport slave (
      input  req_valid, req_addr, req_off, req_last, port_ready,
      output gnt, port_valid, port_addr, port_off, port_last, port_src, busy
   );
endinterface

// File: rtl/vrf_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing one VRF access port between
// NUM_REQ address-generation streams. A burst owns the port from its first
// beat through its last beat; accepted beats land in a registered,
// backpressurable output stage.
module vrf_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int OFF_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   vrf_port_arbiter_if.slave bus_if
);
   localparam int SRC_W = $clog2(NUM_REQ);
   localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);
   localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ-1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [SRC_W-1:0]        owner_q, owner_d;
   logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic                    port_valid_q, port_valid_d;
   logic [ADDR_WIDTH-1:0]   port_addr_q, port_addr_d;
   logic [OFF_WIDTH-1:0]    port_off_q, port_off_d;
   logic                    port_last_q, port_last_d;
   logic [SRC_W-1:0]        port_src_q, port_src_d;

   logic                    can_load_s;
   logic                    any_s;
   logic [SRC_W-1:0]        sel_s;
   logic [SRC_W-1:0]        win_s;
   logic                    accept_s;
   logic [ADDR_WIDTH-1:0]   win_addr_s;
   logic [OFF_WIDTH-1:0]    win_off_s;
   logic                    win_last_s;
   logic [NUM_REQ-1:0]      gnt_s;

   // Successor of a requester index, wrapping at NUM_REQ (not a power of two in general)
   function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx);
      if (idx == LAST_IDX) begin
         return {SRC_W{1'b0}};
      end else begin
         return idx + SRC_W'(1);
      end
   endfunction

   // Cyclic search for the first valid requester starting at rr_ptr
   always_comb begin
      logic [SRC_W:0] sum_v;
      any_s = 1'b0;
      sel_s = {SRC_W{1'b0}};
      sum_v = {(SRC_W+1){1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         sum_v = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
         if (sum_v >= NUM_REQ_W) begin
            sum_v = sum_v - NUM_REQ_W;
         end else begin
            sum_v = sum_v;
         end
         if (!any_s && bus_if.req_valid[sum_v[SRC_W-1:0]]) begin
            any_s = 1'b1;
            sel_s = sum_v[SRC_W-1:0];
         end else begin
            any_s = any_s;
         end
      end
   end

   // Winner selection, beat acceptance and the combinational grant vector
   always_comb begin
      can_load_s = ~port_valid_q | bus_if.port_ready;
      win_s      = (state_q == LOCKED) ? owner_q : sel_s;
      if (state_q == LOCKED) begin
         accept_s = can_load_s & bus_if.req_valid[owner_q];
      end else begin
         accept_s = can_load_s & any_s;
      end
      win_addr_s = {ADDR_WIDTH{1'b0}};
      win_off_s  = {OFF_WIDTH{1'b0}};
      win_last_s = 1'b0;
      gnt_s      = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_s == SRC_W'(i)) begin
            win_addr_s = bus_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_off_s  = bus_if.req_off[i*OFF_WIDTH +: OFF_WIDTH];
            win_last_s = bus_if.req_last[i];
            // In LOCKED the owner sees ready even while it is not valid (bubble)
            gnt_s[i]   = ~rst & can_load_s & ((state_q == LOCKED) | any_s);
         end else begin
            gnt_s[i]   = 1'b0;
         end
      end
   end

   // Next-state logic for the burst lock and the output stage
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      port_valid_d = port_valid_q;
      port_addr_d  = port_addr_q;
      port_off_d   = port_off_q;
      port_last_d  = port_last_q;
      port_src_d   = port_src_q;
      case (state_q)
         IDLE: begin
            if (accept_s && win_last_s) begin
               rr_ptr_d = next_ptr(sel_s);
            end else if (accept_s) begin
               state_d = LOCKED;
               owner_d = sel_s;
            end else begin
               state_d = IDLE;
            end
         end
         LOCKED: begin
            if (accept_s && win_last_s) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr(owner_q);
            end else begin
               state_d = LOCKED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept_s) begin
         port_valid_d = 1'b1;
         port_addr_d  = win_addr_s;
         port_off_d   = win_off_s;
         port_last_d  = win_last_s;
         port_src_d   = win_s;
      end else if (bus_if.port_ready) begin
         port_valid_d = 1'b0;
      end else begin
         port_valid_d = port_valid_q;
      end
   end

   // State and output registers; reset drops any in-flight burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= {SRC_W{1'b0}};
         rr_ptr_q     <= {SRC_W{1'b0}};
         port_valid_q <= 1'b0;
         port_addr_q  <= {ADDR_WIDTH{1'b0}};
         port_off_q   <= {OFF_WIDTH{1'b0}};
         port_last_q  <= 1'b0;
         port_src_q   <= {SRC_W{1'b0}};
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         port_valid_q <= port_valid_d;
         port_addr_q  <= port_addr_d;
         port_off_q   <= port_off_d;
         port_last_q  <= port_last_d;
         port_src_q   <= port_src_d;
      end
   end

   assign bus_if.gnt        = gnt_s;
   assign bus_if.port_valid = port_valid_q;
   assign bus_if.port_addr  = port_addr_q;
   assign bus_if.port_off   = port_off_q;
   assign bus_if.port_last  = port_last_q;
   assign bus_if.port_src   = port_src_q;
   assign bus_if.busy       = (state_q == LOCKED) | port_valid_q;
endmodule

// File: tb/tb_vrf_port_arbiter.sv
// Bench for vrf_port_arbiter: a directed table with hand-computed expectations,
// then randomized bursts, all cross-checked every cycle against a
// behavioural model of the arbitration rules.
module tb_vrf_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 5;
   localparam int OW = 8;
   localparam int NROW = 29;
   localparam int NRAND = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   vrf_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .OFF_WIDTH(OW)) bus ();

   vrf_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .OFF_WIDTH(OW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: post-edge view of the lock, pointer and output beat
   bit          m_locked = 1'b0;
   int          m_owner = 0;
   int          m_rr = 0;
   bit          m_pv = 1'b0;
   int          m_addr = 0, m_off = 0, m_last = 0, m_src = 0;
   logic [N-1:0] m_xfer = '0;

   // Per-cycle compare against the model, then advance the model to the next edge
   always @(negedge clk) begin : cmp
      logic [N-1:0] g;
      bit  can, found, lst;
      int  w, idx;
      if (rst) begin
         chk("rst_gnt", bus.gnt, 0);
         chk("rst_port_valid", bus.port_valid, 0);
         chk("rst_busy", bus.busy, 0);
         m_locked = 1'b0; m_owner = 0; m_rr = 0; m_pv = 1'b0;
         m_addr = 0; m_off = 0; m_last = 0; m_src = 0; m_xfer = '0;
      end else begin
         chk("port_valid", bus.port_valid, m_pv);
         if (m_pv) begin
            chk("port_addr", bus.port_addr, m_addr);
            chk("port_off", bus.port_off, m_off);
            chk("port_last", bus.port_last, m_last);
            chk("port_src", bus.port_src, m_src);
         end
         chk("busy", bus.busy, (m_locked || m_pv) ? 1 : 0);
         can = !m_pv || bus.port_ready;
         g = '0;
         found = 1'b0;
         if (can && m_locked) begin
            g[m_owner] = 1'b1;
         end else if (can) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_rr + k) % N;
               if (!found && bus.req_valid[idx]) begin
                  g[idx] = 1'b1;
                  found = 1'b1;
               end
            end
         end
         chk("gnt", bus.gnt, g);
         m_xfer = g & bus.req_valid;
         w = -1;
         for (int i = 0; i < N; i++) if (m_xfer[i]) w = i;
         if (w >= 0) begin
            lst = bus.req_last[w];
            for (int i = 0; i < N; i++) begin
               if (i == w) begin
                  m_addr = bus.req_addr[i*AW +: AW];
                  m_off  = bus.req_off[i*OW +: OW];
               end
            end
            m_pv = 1'b1; m_last = lst; m_src = w;
            if (m_locked) begin
               if (lst) begin m_locked = 1'b0; m_rr = (w + 1) % N; end
            end else begin
               if (!lst) begin m_locked = 1'b1; m_owner = w; end
               else m_rr = (w + 1) % N;
            end
         end else if (bus.port_ready) begin
            m_pv = 1'b0;
         end
      end
   end

   // Directed table: each row drives one cycle (all offsets = row number,
   // addr of requester i = 5+i) and states the expected outputs seen that cycle.
   bit         t_rst [NROW] = '{1,0,0,0,0,0,0,1,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
   logic [3:0] t_v   [NROW] = '{4'b0000,4'b0100,4'b0100,4'b0100,4'b0100,4'b1001,4'b1000,4'b1000,
                                4'b0110,4'b0000,4'b0000,4'b0001,4'b0011,4'b0001,4'b0001,4'b0011,
                                4'b0011,4'b0001,4'b0100,4'b0100,4'b0100,4'b0100,4'b0100,4'b0000,
                                4'b0000,4'b1111,4'b1111,4'b1111,4'b1111};
   logic [3:0] t_l   [NROW] = '{4'b0000,4'b0000,4'b0000,4'b0000,4'b0100,4'b1001,4'b0000,4'b0000,
                                4'b0110,4'b0000,4'b0000,4'b0001,4'b0001,4'b0001,4'b0001,4'b0001,
                                4'b0011,4'b0001,4'b0000,4'b0000,4'b0000,4'b0000,4'b0100,4'b0000,
                                4'b0000,4'b1111,4'b1111,4'b1111,4'b1111};
   bit         t_rdy [NROW] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,1,1,1,1,1,1,1};
   logic [3:0] t_g   [NROW] = '{4'b0000,4'b0100,4'b0100,4'b0100,4'b0100,4'b1000,4'b1000,4'b0000,
                                4'b0010,4'b0000,4'b0000,4'b0001,4'b0010,4'b0010,4'b0010,4'b0010,
                                4'b0010,4'b0001,4'b0100,4'b0000,4'b0000,4'b0000,4'b0100,4'b0000,
                                4'b0000,4'b1000,4'b0001,4'b0010,4'b0100};
   bit         t_pv  [NROW] = '{0,0,1,1,1,1,1,0,0,1,0,0,1,1,0,0,1,1,1,1,1,1,1,1,0,0,1,1,1};
   int         t_off [NROW] = '{0,0,1,2,3,4,5,0,0,8,0,0,11,12,0,0,15,16,17,18,18,18,18,22,0,0,25,26,27};
   int         t_src [NROW] = '{0,0,2,2,2,2,3,0,0,1,0,0,0,1,0,0,1,1,0,2,2,2,2,2,0,0,3,0,1};
   bit         t_bsy [NROW] = '{0,0,1,1,1,1,1,0,0,1,0,0,1,1,1,1,1,1,1,1,1,1,1,1,0,0,1,1,1};

   // Random requester state: current beat and beats left in the burst
   int r_addr [N];
   int r_off  [N];
   int r_rem  [N];

   task automatic new_burst(input int i);
      r_rem[i]  = $urandom_range(1, 4);
      r_addr[i] = $urandom_range(0, 31);
      r_off[i]  = $urandom_range(0, 200);
   endtask

   initial begin
      bus.req_valid  = '0;
      bus.req_addr   = '0;
      bus.req_off    = '0;
      bus.req_last   = '0;
      bus.port_ready = 1'b1;

      for (int r = 0; r < NROW; r++) begin
         @(posedge clk);
         #1;
         rst            = t_rst[r];
         bus.req_valid  = t_v[r];
         bus.req_last   = t_l[r];
         bus.port_ready = t_rdy[r];
         for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(5 + i);
            bus.req_off[i*OW +: OW]  = OW'(r);
         end
         #1;
         chk("dir_gnt", bus.gnt, t_g[r]);
         chk("dir_port_valid", bus.port_valid, t_pv[r]);
         chk("dir_busy", bus.busy, t_bsy[r]);
         if (t_pv[r]) begin
            chk("dir_port_off", bus.port_off, t_off[r]);
            chk("dir_port_src", bus.port_src, t_src[r]);
            chk("dir_port_addr", bus.port_addr, 5 + t_src[r]);
         end
      end

      for (int i = 0; i < N; i++) new_burst(i);
      for (int c = 0; c < NRAND; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (m_xfer[i]) begin
               r_rem[i]--;
               r_off[i]++;
               if (r_rem[i] == 0) new_burst(i);
            end
         end
         rst = ($urandom_range(0, 399) == 0);
         if (rst) begin
            for (int i = 0; i < N; i++) new_burst(i);
         end
         for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(r_addr[i]);
            bus.req_off[i*OW +: OW]  = OW'(r_off[i]);
            bus.req_last[i]          = (r_rem[i] == 1);
            bus.req_valid[i]         = ($urandom_range(0, 99) < 70);
         end
         bus.port_ready = ($urandom_range(0, 99) < 75);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vrf_port_arbiter.md
# vrf_port_arbiter

Round-robin, burst-locking arbiter that shares one vector register file (VRF) access port between up to eight address-generation streams. Each requester presents one beat per cycle: a register address, an offset, and a last flag. The arbiter grants whole bursts, from the first beat through the beat marked last, and never interleaves requesters inside a burst. Accepted beats go into a registered, backpressurable output stage that drives the VRF port.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..8 (need not be a power of two).
- ADDR_WIDTH, 5: VRF register address width.
- OFF_WIDTH, 8: beat offset width within a register.
- SRC_W, $clog2(NUM_REQ): requester index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_addr  in  NUM_REQ*ADDR_WIDTH  beat register address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_off  in  NUM_REQ*OFF_WIDTH  beat offset, packed the same way.
- req_last  in  NUM_REQ  beat is the final beat of its burst.
- gnt  out  NUM_REQ  one-hot or zero; combinational ready to each requester.
- port_valid  out  1  output beat valid.
- port_addr  out  ADDR_WIDTH  output register address.
- port_off  out  OFF_WIDTH  output offset.
- port_last  out  1  output beat closes its burst.
- port_src  out  SRC_W  index of the requester that produced the output beat.
- port_ready  in  1  VRF accepts the output beat this cycle.
- busy  out  1  equals (state == LOCKED) | port_valid.

## Operation
- State machine has two states, IDLE and LOCKED. Registered state also includes owner[SRC_W] and rr_ptr[SRC_W].
- can_load = ~port_valid | port_ready.
- **IDLE:**
  - sel is the first i with req_valid[i], searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, … wrapping modulo NUM_REQ).
  - If any req_valid and can_load: gnt[sel]=1 and the beat is accepted.
  - If the accepted beat has req_last=0: state→LOCKED and owner←sel.
  - If req_last=1 (single-beat burst): stay IDLE and rr_ptr←(sel+1) mod NUM_REQ.
- **LOCKED:**
  - gnt[owner] = can_load; every other gnt bit is 0.
  - A beat is accepted when req_valid[owner] & gnt[owner].
  - An accepted beat with req_last=1 sets state→IDLE and rr_ptr←(owner+1) mod NUM_REQ.
  - If the owner deasserts valid mid-burst, the lock holds and nothing is granted to anyone (bubble). The lock never times out.
- **Handshake:**
  - Requesters must not make req_valid depend on gnt.
  - A beat transfers only in a cycle where req_valid[i] & gnt[i].
  - gnt must never be asserted to a requester that is not valid in IDLE. In LOCKED, gnt[owner] may be high while its valid is low; no transfer occurs.
- **Output stage:**
  - On accept: port_valid←1, and port_addr/off/last/src load from the winning beat.
  - Otherwise, if port_ready: port_valid←0 and the data registers hold.
  - The port_* outputs stay stable while port_valid & ~port_ready.
- **Reset (asynchronous, any time including mid-burst):**
  - state=IDLE, owner=0, rr_ptr=0.
  - port_valid=0, port_addr=0, port_off=0, port_last=0, port_src=0.
  - busy=0; gnt=0 while rst is high.
  - An in-flight burst is dropped. Requesters restart by presenting their first beat again.

## Timing
- Beat latency is one cycle: a beat accepted at edge N appears on port_* after edge N.
- Sustained throughput is one beat per cycle while port_ready=1.
- Back-to-back bursts need no dead cycle:
  - The last beat is accepted in LOCKED at edge N.
  - The next cycle is IDLE, and it arbitrates and grants with the updated rr_ptr.
- Backpressure: port_ready=0 with port_valid=1 drives all gnt bits to 0 in the same cycle (combinational).
- Fairness: after a burst from i ends, every other requester with valid held continuously is granted before i is granted again (worst case NUM_REQ-1 bursts).

## Test plan
- **Single requester:** req 2 presents a 4-beat burst (addr 5, off 0..3, last on off 3) with port_ready=1.
  - gnt[2]=1 for 4 consecutive cycles.
  - port_off sequence 0,1,2,3 one cycle later, port_src=2, port_last only on off 3.
  - rr_ptr ends at 3.
- **Round-robin:** all 4 requesters continuously present single-beat bursts from reset.
  - Grant order 0,1,2,3,0,1… with one beat per cycle.
- **Lock:** req 1 starts a 3-beat burst while req 0 is valid throughout, and req 1 drops valid for 2 cycles after beat 1.
  - gnt[0] stays 0 until req 1's last beat is accepted.
  - port_valid shows a 2-cycle gap.
  - req 0 is granted the next cycle.
- **Backpressure:** port_ready=0 for 3 cycles mid-burst.
  - gnt=0 during the stall; port_* hold their values.
  - No beat is lost or duplicated (compare against a scoreboard).
- **Reset mid-burst:** assert rst while LOCKED with owner=3 and port_valid=1.
  - Immediately: port_valid=0, gnt=0, busy=0.
  - After release, the first grant goes to the lowest-index valid requester (rr_ptr=0).
- **NUM_REQ=3 wrap:** a burst from req 2 completes.
  - rr_ptr wraps to 0; req 0 is granted before req 1 when both are valid.
